rca_lsu_arbiter: RTL and testbench

Shares the core's single LSU between the Taiga load/store issue path and the RCA load/store queue. A four-state ownership machine, driven by the RCA LSU lock, grants the LSU to exactly one requester at a time. Before ownership changes, the arbiter drains all loads still in flight. Load results are routed back to whichever side issued them. The block sits between the RCA LSQ, the core's LSU issue stage and the LSU itself.

---
 rtl/rca_lsu_arbiter.sv | 160 ++++++++++++++++
 tb/tb_rca_lsu_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rca_lsu_arbiter.sv
// Arbitrates the single core LSU between the Taiga issue path and the RCA load/store queue.
// Ownership changes only after all in-flight loads have drained, so completions route by one issuer bit.
`timescale 1ns/1ps
module rca_lsu_arbiter #(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            core_req_valid,
  output logic            core_req_ready,
  input  logic [XLEN-1:0] core_rs1,
  input  logic [XLEN-1:0] core_rs2,
  input  logic [2:0]      core_fn3,
  input  logic            core_load,
  input  logic            core_store,
  input  logic            rca_lock,
  input  logic            rca_req_valid,
  output logic            rca_req_ready,
  input  logic [XLEN-1:0] rca_rs1,
  input  logic [XLEN-1:0] rca_rs2,
  input  logic [2:0]      rca_fn3,
  input  logic            rca_load,
  input  logic            rca_store,
  input  logic            lsu_ready,
  output logic            lsu_new_request,
  output logic [XLEN-1:0] lsu_rs1,
  output logic [XLEN-1:0] lsu_rs2,
  output logic [2:0]      lsu_fn3,
  output logic            lsu_load,
  output logic            lsu_store,
  input  logic            lsu_load_complete,
  input  logic [XLEN-1:0] lsu_load_data,
  output logic [XLEN-1:0] load_data,
  output logic            core_load_complete,
  output logic            rca_load_complete,
  output logic            rca_granted,
  output logic            unexpected_completion
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    CORE_OWN      = 2'd0,
    DRAIN_TO_RCA  = 2'd1,
    RCA_OWN       = 2'd2,
    DRAIN_TO_CORE = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_issuer;
  logic             r_rca_granted;
  logic             r_unexpected;

  logic w_full;
  logic w_count_zero;
  logic w_core_ready;
  logic w_rca_ready;
  logic w_issue_core;
  logic w_issue_rca;
  logic w_load_issue;
  logic w_cmp_valid;

  assign w_full       = (r_count == CNT_MAX);
  assign w_count_zero = (r_count == '0);

  // Readies are gated by rst so nothing leaks out while the machine is being reset.
  assign w_core_ready = ~rst & (r_state == CORE_OWN) & lsu_ready & ~rca_lock & ~w_full;
  assign w_rca_ready  = ~rst & (r_state == RCA_OWN) & lsu_ready & ~w_full;

  assign w_issue_core = core_req_valid & w_core_ready;
  assign w_issue_rca  = rca_req_valid & w_rca_ready;
  assign w_load_issue = (w_issue_core & core_load & ~core_store) |
                        (w_issue_rca & rca_load & ~rca_store);
  assign w_cmp_valid  = lsu_load_complete & ~w_count_zero;

  assign core_req_ready  = w_core_ready;
  assign rca_req_ready   = w_rca_ready;
  assign lsu_new_request = w_issue_core | w_issue_rca;

  always_comb begin
    lsu_rs1   = core_rs1;
    lsu_rs2   = core_rs2;
    lsu_fn3   = core_fn3;
    lsu_load  = core_load;
    lsu_store = core_store;
    if (r_state == RCA_OWN) begin
      lsu_rs1   = rca_rs1;
      lsu_rs2   = rca_rs2;
      lsu_fn3   = rca_fn3;
      lsu_load  = rca_load;
      lsu_store = rca_store;
    end
  end

  assign load_data             = lsu_load_data;
  assign core_load_complete    = ~rst & w_cmp_valid & ~r_issuer;
  assign rca_load_complete     = ~rst & w_cmp_valid & r_issuer;
  assign rca_granted           = r_rca_granted;
  assign unexpected_completion = r_unexpected;

  // A completion with nothing outstanding is not counted, only flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count      <= '0;
      r_issuer     <= 1'b0;
      r_unexpected <= 1'b0;
    end else begin
      case ({w_load_issue, w_cmp_valid})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_load_issue)
        r_issuer <= w_issue_rca;
      if (lsu_load_complete & w_count_zero)
        r_unexpected <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= CORE_OWN;
      r_rca_granted <= 1'b0;
    end else begin
      case (r_state)
        CORE_OWN: begin
          if (rca_lock)
            r_state <= DRAIN_TO_RCA;
        end
        DRAIN_TO_RCA: begin
          if (!rca_lock) begin
            r_state <= CORE_OWN;
          end else if (w_count_zero) begin
            r_state       <= RCA_OWN;
            r_rca_granted <= 1'b1;
          end
        end
        RCA_OWN: begin
          if (!rca_lock) begin
            r_state       <= DRAIN_TO_CORE;
            r_rca_granted <= 1'b0;
          end
        end
        DRAIN_TO_CORE: begin
          if (w_count_zero)
            r_state <= CORE_OWN;
        end
        default: begin
          r_state       <= CORE_OWN;
          r_rca_granted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_lsu_arbiter.sv
// Scoreboard bench for rca_lsu_arbiter: a queue-of-issuers ownership model predicts every cycle's outputs.
`timescale 1ns/1ps
module tb_rca_lsu_arbiter;

  localparam int XLEN = 32;
  localparam int MAXO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            core_req_valid, core_req_ready;
  logic [XLEN-1:0] core_rs1, core_rs2;
  logic [2:0]      core_fn3;
  logic            core_load, core_store;
  logic            rca_lock;
  logic            rca_req_valid, rca_req_ready;
  logic [XLEN-1:0] rca_rs1, rca_rs2;
  logic [2:0]      rca_fn3;
  logic            rca_load, rca_store;
  logic            lsu_ready, lsu_new_request;
  logic [XLEN-1:0] lsu_rs1, lsu_rs2;
  logic [2:0]      lsu_fn3;
  logic            lsu_load, lsu_store;
  logic            lsu_load_complete;
  logic [XLEN-1:0] lsu_load_data, load_data;
  logic            core_load_complete, rca_load_complete;
  logic            rca_granted, unexpected_completion;

  rca_lsu_arbiter #(.XLEN(XLEN), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_rs1(core_rs1), .core_rs2(core_rs2), .core_fn3(core_fn3),
    .core_load(core_load), .core_store(core_store),
    .rca_lock(rca_lock),
    .rca_req_valid(rca_req_valid), .rca_req_ready(rca_req_ready),
    .rca_rs1(rca_rs1), .rca_rs2(rca_rs2), .rca_fn3(rca_fn3),
    .rca_load(rca_load), .rca_store(rca_store),
    .lsu_ready(lsu_ready), .lsu_new_request(lsu_new_request),
    .lsu_rs1(lsu_rs1), .lsu_rs2(lsu_rs2), .lsu_fn3(lsu_fn3),
    .lsu_load(lsu_load), .lsu_store(lsu_store),
    .lsu_load_complete(lsu_load_complete), .lsu_load_data(lsu_load_data),
    .load_data(load_data),
    .core_load_complete(core_load_complete), .rca_load_complete(rca_load_complete),
    .rca_granted(rca_granted), .unexpected_completion(unexpected_completion)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            core_rdy, rca_rdy, newreq, ccmp, rcmp, granted, err;
    logic [XLEN-1:0] rs1, rs2, ldata;
    logic [2:0]      fn3;
    logic            ld, st;
    bit              chk_regs;
  } exp_t;

  exp_t exp_q[$];
  int   n_err = 0;
  int   n_chk = 0;

  // Model: which side owns the LSU, whether a handover is pending, and who issued each load in flight.
  bit m_rca_side = 1'b0;
  bit m_handover = 1'b0;
  bit m_err      = 1'b0;
  bit m_known    = 1'b0;
  bit inflight[$];

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("core_req_ready", core_req_ready, e.core_rdy);
      chk("rca_req_ready", rca_req_ready, e.rca_rdy);
      chk("lsu_new_request", lsu_new_request, e.newreq);
      chk("core_load_complete", core_load_complete, e.ccmp);
      chk("rca_load_complete", rca_load_complete, e.rcmp);
      chk("load_data", load_data, e.ldata);
      if (e.chk_regs) begin
        chk("rca_granted", rca_granted, e.granted);
        chk("unexpected_completion", unexpected_completion, e.err);
        chk("lsu_rs1", lsu_rs1, e.rs1);
        chk("lsu_rs2", lsu_rs2, e.rs2);
        chk("lsu_fn3", lsu_fn3, e.fn3);
        chk("lsu_load", lsu_load, e.ld);
        chk("lsu_store", lsu_store, e.st);
      end
    end
  end

  // Predict this cycle's outputs, hand them to the monitor, then advance the model across the edge.
  task automatic step();
    exp_t e;
    int   n;
    bit   full, owner_active, cmp_ok, core_iss, rca_iss, ld_iss;
    n            = inflight.size();
    full         = (n == MAXO);
    owner_active = !m_handover;
    e.core_rdy   = !rst && !m_rca_side && owner_active && lsu_ready && !rca_lock && !full;
    e.rca_rdy    = !rst && m_rca_side && owner_active && lsu_ready && !full;
    core_iss     = core_req_valid && e.core_rdy;
    rca_iss      = rca_req_valid && e.rca_rdy;
    e.newreq     = core_iss || rca_iss;
    if (m_rca_side && owner_active) begin
      e.rs1 = rca_rs1; e.rs2 = rca_rs2; e.fn3 = rca_fn3; e.ld = rca_load; e.st = rca_store;
    end else begin
      e.rs1 = core_rs1; e.rs2 = core_rs2; e.fn3 = core_fn3; e.ld = core_load; e.st = core_store;
    end
    cmp_ok     = lsu_load_complete && (n > 0);
    e.ccmp     = !rst && cmp_ok && (inflight[0] == 1'b0);
    e.rcmp     = !rst && cmp_ok && (inflight[0] == 1'b1);
    e.ldata    = lsu_load_data;
    e.granted  = m_rca_side && owner_active;
    e.err      = m_err;
    e.chk_regs = m_known;
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      inflight.delete();
      m_rca_side = 1'b0;
      m_handover = 1'b0;
      m_err      = 1'b0;
      m_known    = 1'b1;
    end else begin
      ld_iss = (core_iss && core_load && !core_store) || (rca_iss && rca_load && !rca_store);
      if (lsu_load_complete && n == 0) m_err = 1'b1;
      if (cmp_ok) void'(inflight.pop_front());
      if (ld_iss) inflight.push_back(rca_iss);
      if (!m_handover) begin
        if (m_rca_side != rca_lock) m_handover = 1'b1;
      end else if (!m_rca_side) begin
        if (!rca_lock) m_handover = 1'b0;
        else if (n == 0) begin m_rca_side = 1'b1; m_handover = 1'b0; end
      end else if (n == 0) begin
        m_rca_side = 1'b0;
        m_handover = 1'b0;
      end
    end
    #1;
  endtask

  task automatic cyc(input bit cv, input bit rv, input bit lock, input bit cmp, input logic [XLEN-1:0] a);
    rst = 1'b0;
    core_req_valid = cv; core_load = 1'b1; core_store = 1'b0; core_rs1 = ~a; core_rs2 = a + 32'd7; core_fn3 = 3'd2;
    rca_req_valid  = rv; rca_load  = 1'b1; rca_store  = 1'b0; rca_rs1  = a;  rca_rs2  = a + 32'd9; rca_fn3  = 3'd4;
    rca_lock = lock; lsu_ready = 1'b1; lsu_load_complete = cmp; lsu_load_data = a;
    step();
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      rst = 1'b1;
      step();
    end
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int n;
    rst = 1'b1; core_req_valid = 1'b0; rca_req_valid = 1'b0; rca_lock = 1'b0; lsu_ready = 1'b1;
    core_load = 1'b0; core_store = 1'b0; rca_load = 1'b0; rca_store = 1'b0;
    core_rs1 = '0; core_rs2 = '0; core_fn3 = '0; rca_rs1 = '0; rca_rs2 = '0; rca_fn3 = '0;
    lsu_load_complete = 1'b0; lsu_load_data = '0;
    @(posedge clk); #1;
    do_reset(2);

    // Four back-to-back core loads fill the tracker; the fifth is held off.
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 32'h100 + 32'(i * 4));
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 32'hC0DE0000 + 32'(i));
    cyc(0, 0, 0, 0, 32'h0);

    // Handover to RCA with two core loads still outstanding.
    cyc(1, 0, 0, 0, 32'h200); cyc(1, 0, 0, 0, 32'h204);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 32'h208);
    cyc(0, 0, 1, 1, 32'h11110000); cyc(0, 0, 1, 1, 32'h22220000);
    cyc(0, 0, 1, 0, 32'h0); cyc(0, 0, 1, 0, 32'h0);
    cyc(0, 1, 1, 0, 32'h1000);
    cyc(0, 0, 1, 1, 32'hDEADBEEF);

    // Lock drops with one RCA load in flight.
    cyc(0, 1, 1, 0, 32'h2000);
    cyc(1, 0, 0, 0, 32'h300); cyc(1, 0, 0, 0, 32'h304);
    cyc(1, 0, 0, 1, 32'hAAAA5555);
    cyc(1, 0, 0, 0, 32'h308); cyc(1, 0, 0, 0, 32'h30C);

    // Same-cycle issue and completion, then a completion with nothing outstanding.
    cyc(1, 0, 0, 0, 32'h310);
    cyc(1, 0, 0, 1, 32'h314);
    cyc(0, 0, 0, 1, 32'h1); cyc(0, 0, 0, 1, 32'h2);
    cyc(0, 0, 0, 1, 32'h3);
    cyc(0, 0, 0, 0, 32'h0); cyc(0, 0, 0, 0, 32'h0);

    // Reset while draining toward the RCA with three loads outstanding.
    do_reset(1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 32'h400 + 32'(i));
    cyc(0, 0, 1, 0, 32'h0); cyc(0, 0, 1, 0, 32'h0);
    rst = 1'b1; lsu_load_complete = 1'b1; core_req_valid = 1'b1; step();
    cyc(0, 0, 0, 1, 32'h5);
    cyc(0, 0, 0, 0, 32'h0);
    do_reset(1);

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) rca_lock = ~rca_lock;
      core_req_valid = 1'($urandom_range(0, 1));
      core_load      = 1'($urandom_range(0, 1));
      core_store     = ($urandom_range(0, 7) == 0) ? core_load : ~core_load;
      core_rs1 = $urandom; core_rs2 = $urandom; core_fn3 = 3'($urandom_range(0, 7));
      rca_req_valid  = 1'($urandom_range(0, 1));
      rca_load       = 1'($urandom_range(0, 1));
      rca_store      = ($urandom_range(0, 7) == 0) ? rca_load : ~rca_load;
      rca_rs1 = $urandom; rca_rs2 = $urandom; rca_fn3 = 3'($urandom_range(0, 7));
      lsu_ready = ($urandom_range(0, 3) != 0);
      n = inflight.size();
      lsu_load_complete = (n > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
      lsu_load_data = $urandom;
      step();
    end
    do_reset(1);

    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
